// File: rtl/usart_rx_core.sv
// usart_rx_core: UART receiver (start, DATA_BIT data LSB first, [even parity], stop)
// with mid-bit sampling and an NUM_OF_BUFS-deep show-ahead receive FIFO.
// Optional feature macro: RX_PARITY_EN adds one even-parity bit before the stop bit.
module usart_rx_core #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BIT    = 8,
    parameter int NUM_OF_BUFS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rx,
    output logic [DATA_BIT-1:0]              rd_data,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [$clog2(NUM_OF_BUFS):0]     fifo_count,
    output logic                             frame_err,
    output logic                             overrun,
    output logic                             parity_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BIT + 1);
    localparam int PTR_W = $clog2(NUM_OF_BUFS);
    localparam int CW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BIT - 1);
    localparam logic [CW-1:0]    DEPTH    = CW'(NUM_OF_BUFS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic                  sync1_r, rx_s, rx_prev_r;
    logic [CNT_W-1:0]      clk_cnt_r, clk_cnt_next_s;
    logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_next_s;
    logic [DATA_BIT-1:0]   shift_r, shift_next_s;
    logic                  par_r, par_next_s;
    logic                  push_req_r, push_req_next_s;
    logic                  frame_err_next_s, parity_err_next_s;
    logic                  parity_ok_s;
    logic                  frame_err_r, parity_err_r, overrun_r;

    logic [DATA_BIT-1:0]   mem_r [NUM_OF_BUFS];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  pop_s, full_s, do_push_s;

    // Even parity over data plus received parity bit must be zero.
    function automatic logic even_parity_ok(input logic [DATA_BIT-1:0] d, input logic p);
        even_parity_ok = ((^d) ^ p) == 1'b0;
    endfunction

`ifdef RX_PARITY_EN
    assign parity_ok_s = even_parity_ok(shift_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Two-flop synchronizer plus previous-sample flop for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rx;
            rx_s      <= sync1_r;
            rx_prev_r <= rx_s;
        end
    end

    // Receive FSM next-state, counters, shifter and frame verdict.
    always_comb begin
        state_next_s      = state_r;
        clk_cnt_next_s    = clk_cnt_r + CNT_W'(1);
        bit_cnt_next_s    = bit_cnt_r;
        shift_next_s      = shift_r;
        par_next_s        = par_r;
        push_req_next_s   = 1'b0;
        frame_err_next_s  = 1'b0;
        parity_err_next_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                clk_cnt_next_s = '0;
                if (rx_prev_r && !rx_s) begin
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                if (clk_cnt_r == HALF_M1) begin
                    clk_cnt_next_s = '0;
                    bit_cnt_next_s = '0;
                    // A start that is high again by mid-bit was a glitch.
                    state_next_s   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_next_s = S_START;
                end
            end
            S_DATA: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_next_s = '0;
                    shift_next_s   = {rx_s, shift_r[DATA_BIT-1:1]};
                    bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef RX_PARITY_EN
                        state_next_s = S_PARITY;
`else
                        state_next_s = S_STOP;
`endif
                    end else begin
                        state_next_s = S_DATA;
                    end
                end else begin
                    state_next_s = S_DATA;
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_next_s = '0;
                    par_next_s     = rx_s;
                    state_next_s   = S_STOP;
                end else begin
                    state_next_s = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_next_s = '0;
                    state_next_s   = S_IDLE;
                    if (!rx_s) begin
                        frame_err_next_s = 1'b1;
                    end else if (!parity_ok_s) begin
                        parity_err_next_s = 1'b1;
                    end else begin
                        push_req_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = S_STOP;
                end
            end
            default: begin
                state_next_s   = S_IDLE;
                clk_cnt_next_s = '0;
            end
        endcase
    end

    // FSM state, counters, shifter and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            par_r        <= 1'b0;
            push_req_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            clk_cnt_r    <= clk_cnt_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            shift_r      <= shift_next_s;
            par_r        <= par_next_s;
            push_req_r   <= push_req_next_s;
            frame_err_r  <= frame_err_next_s;
            parity_err_r <= parity_err_next_s;
        end
    end

    assign pop_s     = (count_r != '0) && rd_ready;
    assign full_s    = (count_r == DEPTH);
    assign do_push_s = push_req_r && (!full_s || pop_s);

    // Circular FIFO: a push while full succeeds only alongside a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OF_BUFS; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r   <= count_r + CW'(do_push_s) - CW'(pop_s);
            overrun_r <= push_req_r && full_s && !pop_s;
        end
    end

    assign rd_data    = mem_r[rd_ptr_r];
    assign rd_valid   = (count_r != '0);
    assign fifo_count = count_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign parity_err = parity_err_r;
endmodule
